seven_segment_decoder: RTL and testbench
========================================

# seven_segment_decoder

Receive-side counterpart to the board's hex-to-segment driver. The block samples a 7-bit active-low segment pattern (abcdefg) on a strobe and waits until the pattern is stable. It then decodes the pattern back to a 4-bit hex value and offers that value on a valid/ready handshake. It sits in loopback and self-check paths, where a driven display bus is read back into the datapath.

## Interface
- STABLE_CYCLES, 3: number of consecutive identical strobed samples needed before a pattern is decoded; minimum 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low.
- seg_in  in  7  segment pattern; bit 6 = a … bit 0 = g; 0 = segment lit.
- seg_stb  in  1  sample enable; seg_in is sampled on edges where this is high.
- hex_out  out  4  decoded value; held stable while hex_valid is high.
- hex_valid  out  1  hex_out holds an undelivered value.
- hex_ready  in  1  consumer accepts the value; a transfer occurs when valid and ready are both high.
- err  out  1  sticky: a stable pattern was not one of the 16 legal codes and not blank.
- overrun  out  1  sticky: a legal stable pattern was dropped because hex_valid was held without ready.
- clr_flags  in  1  clears err and overrun.

## Operation
- Legal codes (hex = abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blank pattern 1111111: never emitted and never flagged.
- Stability filter:
  - Registers: candidate pattern cand[6:0], counter cnt of width clog2(STABLE_CYCLES+1), and flag fired.
  - On a strobe with seg_in == cand: cnt increments and saturates at STABLE_CYCLES.
  - On a strobe with seg_in != cand: cand <= seg_in, cnt <= 1, fired <= 0.
  - Emit event: cnt == STABLE_CYCLES and fired == 0. Fired is then set, so each stable episode emits exactly once.
  - With STABLE_CYCLES = 1, every strobe that changes the pattern is an emit event.
- Emit handling (registered one cycle after the emit condition):
  - Legal code, and either hex_valid == 0 or a transfer is happening this cycle: load hex_out and set hex_valid = 1. No overrun.
  - Legal code, hex_valid == 1 and hex_ready == 0: drop the value and set overrun. hex_out is unchanged.
  - Illegal, non-blank code: set err. hex_valid is unaffected.
- Handshake: on a transfer with no simultaneous load, hex_valid goes to 0 on the next edge.
- Flags: clr_flags clears err and overrun. If a set and a clear happen on the same edge, the set wins.
- Strobes with seg_stb low change no state.

## Timing
- Reset (rst low at an edge): hex_out = 0, hex_valid = 0, err = 0, overrun = 0, cand = 1111111, cnt = 0, fired = 0.
- Reset mid-operation discards any pending value and any in-progress filter count.
- Latency: if the STABLE_CYCLES-th matching strobe is sampled at edge k, hex_valid is high after edge k+1.
- hex_ready is not combinationally fed to any output.
- Throughput: at most one value per stable episode. Back-to-back distinct patterns with STABLE_CYCLES = 1 and ready held high deliver one value per strobe.
- All outputs are registered.

## Configuration
- SEG7_DEC_FILTER_EN defined: the stability filter operates as described above.
- SEG7_DEC_FILTER_EN undefined:
  - STABLE_CYCLES is ignored and cand, cnt and fired are not built.
  - Every strobe is an emit event, including repeats of the same pattern.
  - Latency is fixed at one cycle after the strobe edge.

## Test plan
- Reset and idle: hold rst low for 2 cycles, then high with no strobes. Required: all outputs are 0 and remain 0.
- Filter pass (STABLE_CYCLES = 3, filter on, ready = 1): strobe 0100100 three times. Required: hex_out = 5, hex_valid is high one cycle after the third strobe, and no further valid for additional identical strobes.
- Filter reject: strobe 0000110, 0000110, 0010010, 0000110 (ready = 1). Required: no hex_valid, because cnt restarts on each change.
- Overrun: hold ready = 0, settle 1001111, then settle 0001000. Required: hex_out = 1, hex_valid = 1 and overrun = 1. Then ready = 1 for one cycle gives a transfer, and valid is 0 on the next cycle.
- Illegal and blank: settle 1111110 and then 1111111. Required: err = 1 after the first and no hex_valid for either. Pulsing clr_flags returns err to 0.
- Reset mid-operation: after two of three strobes of 0110000, pulse rst low, then give one strobe. Required: no valid is produced and cnt restarts.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: strobed 7-seg readback, decoded to hex on valid/ready.
// Define SEG7_DEC_FILTER_EN to build the STABLE_CYCLES stability filter.
module seven_segment_decoder #(
   parameter int STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   input  logic       seg_stb,
   output logic [3:0] hex_out,
   output logic       hex_valid,
   input  logic       hex_ready,
   output logic       err,
   output logic       overrun,
   input  logic       clr_flags
);

   localparam logic [6:0] BLANK = 7'b111_1111;

   logic       emit;
   logic [6:0] pat;

`ifdef SEG7_DEC_FILTER_EN
   localparam int            CW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

   logic [6:0]    cand;
   logic [CW-1:0] cnt;
   logic          fired;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cand  <= BLANK;
         cnt   <= '0;
         fired <= 1'b0;
      end else if (seg_stb && seg_in != cand) begin
         cand  <= seg_in;
         cnt   <= CW'(1);
         fired <= 1'b0;
      end else begin
         if (seg_stb && cnt != CMAX)
            cnt <= cnt + CW'(1);
         if (emit)
            fired <= 1'b1;
      end
   end

   assign emit = (cnt == CMAX) && !fired;
   assign pat  = cand;
`else
   // A degenerate STABLE_CYCLES (<1) disables decoding entirely.
   localparam bit CFG_OK = STABLE_CYCLES >= 1;

   logic [6:0] smp;
   logic       smp_vld;

   always_ff @(posedge clk) begin
      if (!rst) begin
         smp     <= BLANK;
         smp_vld <= 1'b0;
      end else begin
         smp_vld <= seg_stb & CFG_OK;
         if (seg_stb)
            smp <= seg_in;
      end
   end

   assign emit = smp_vld;
   assign pat  = smp;
`endif

   logic [3:0] dec;
   logic       legal;

   always_comb begin
      dec   = 4'h0;
      legal = 1'b1;
      case (pat)
         7'b000_0001: dec = 4'h0;
         7'b100_1111: dec = 4'h1;
         7'b001_0010: dec = 4'h2;
         7'b000_0110: dec = 4'h3;
         7'b100_1100: dec = 4'h4;
         7'b010_0100: dec = 4'h5;
         7'b010_0000: dec = 4'h6;
         7'b000_1111: dec = 4'h7;
         7'b000_0000: dec = 4'h8;
         7'b000_1100: dec = 4'h9;
         7'b000_1000: dec = 4'hA;
         7'b110_0000: dec = 4'hB;
         7'b011_0001: dec = 4'hC;
         7'b100_0010: dec = 4'hD;
         7'b011_0000: dec = 4'hE;
         7'b011_1000: dec = 4'hF;
         default:     legal = 1'b0;
      endcase
   end

   logic take;
   logic ld;
   logic set_ov;
   logic set_err;

   assign take    = hex_valid && hex_ready;
   assign ld      = emit && legal && (!hex_valid || hex_ready);
   assign set_ov  = emit && legal && hex_valid && !hex_ready;
   assign set_err = emit && !legal && (pat != BLANK);

   // Flag set takes priority over a same-edge clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hex_out   <= 4'h0;
         hex_valid <= 1'b0;
         err       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (ld) begin
            hex_out   <= dec;
            hex_valid <= 1'b1;
         end else if (take) begin
            hex_valid <= 1'b0;
         end
         err     <= set_err | (err & ~clr_flags);
         overrun <= set_ov | (overrun & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: decode table plus scripted corner sequences;
// every delivered value is matched against a queue of expected hex values.
`timescale 1ns/1ps
module tb_seven_segment_decoder;

`ifdef SEG7_DEC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int SC = 3;
   localparam int NS = FILT ? SC : 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic       seg_stb;
   logic [3:0] hex_out;
   logic       hex_valid;
   logic       hex_ready;
   logic       err;
   logic       overrun;
   logic       clr_flags;

   always #5 clk = ~clk;

   seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .seg_stb   (seg_stb),
      .hex_out   (hex_out),
      .hex_valid (hex_valid),
      .hex_ready (hex_ready),
      .err       (err),
      .overrun   (overrun),
      .clr_flags (clr_flags)
   );

   int nvec = 0;
   int nbad = 0;
   logic [3:0] expq[$];

   typedef struct {
      logic [6:0] seg;
      bit         legal;
      logic [3:0] hex;
      bit         bad;
   } vec_t;

   vec_t       tbl[20];
   logic [6:0] rj_seg[4];
   logic [3:0] rj_hex[4];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Transfer happens at the next rising edge when both are high here.
   always @(negedge clk) begin
      if (hex_valid === 1'b1 && hex_ready === 1'b1) begin
         if (expq.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL unexpected_xfer: got hex %0h want no transfer",
                     hex_out);
         end else begin
            chk("xfer_hex", {28'h0, hex_out}, {28'h0, expq.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [6:0] p);
      seg_in  = p;
      seg_stb = 1'b1;
      tick();
      seg_stb = 1'b0;
   endtask

   task automatic settle(input logic [6:0] p);
      repeat (NS) strobe(p);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{7'b0000001, 1'b1, 4'h0, 1'b0};
      tbl[1]  = '{7'b1001111, 1'b1, 4'h1, 1'b0};
      tbl[2]  = '{7'b0010010, 1'b1, 4'h2, 1'b0};
      tbl[3]  = '{7'b0000110, 1'b1, 4'h3, 1'b0};
      tbl[4]  = '{7'b1001100, 1'b1, 4'h4, 1'b0};
      tbl[5]  = '{7'b0100100, 1'b1, 4'h5, 1'b0};
      tbl[6]  = '{7'b0100000, 1'b1, 4'h6, 1'b0};
      tbl[7]  = '{7'b0001111, 1'b1, 4'h7, 1'b0};
      tbl[8]  = '{7'b0000000, 1'b1, 4'h8, 1'b0};
      tbl[9]  = '{7'b0001100, 1'b1, 4'h9, 1'b0};
      tbl[10] = '{7'b0001000, 1'b1, 4'hA, 1'b0};
      tbl[11] = '{7'b1100000, 1'b1, 4'hB, 1'b0};
      tbl[12] = '{7'b0110001, 1'b1, 4'hC, 1'b0};
      tbl[13] = '{7'b1000010, 1'b1, 4'hD, 1'b0};
      tbl[14] = '{7'b0110000, 1'b1, 4'hE, 1'b0};
      tbl[15] = '{7'b0111000, 1'b1, 4'hF, 1'b0};
      tbl[16] = '{7'b1111110, 1'b0, 4'h0, 1'b1};
      tbl[17] = '{7'b1111111, 1'b0, 4'h0, 1'b0};
      tbl[18] = '{7'b0101010, 1'b0, 4'h0, 1'b1};
      tbl[19] = '{7'b0011100, 1'b0, 4'h0, 1'b1};
      rj_seg  = '{7'b0000110, 7'b0000110, 7'b0010010, 7'b0000110};
      rj_hex  = '{4'h3, 4'h3, 4'h2, 4'h3};

      rst       = 1'b0;
      seg_in    = 7'b1111111;
      seg_stb   = 1'b0;
      hex_ready = 1'b0;
      clr_flags = 1'b0;

      // reset and idle
      tick();
      tick();
      chk("rst_hold", {hex_out, hex_valid, err, overrun}, 0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("idle%0d", i), {hex_out, hex_valid, err, overrun}, 0);
      end

      // decode table
      hex_ready = 1'b1;
      foreach (tbl[i]) begin
         if (tbl[i].legal)
            expq.push_back(tbl[i].hex);
         settle(tbl[i].seg);
         tick();
         chk($sformatf("tbl%0d_valid", i), hex_valid, tbl[i].legal);
         if (tbl[i].legal)
            chk($sformatf("tbl%0d_hex", i), hex_out, tbl[i].hex);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].bad);
         if (tbl[i].bad) begin
            pulse_clr();
            chk($sformatf("tbl%0d_errclr", i), err, 0);
         end
         tick();
         chk($sformatf("tbl%0d_after", i), hex_valid, 0);
      end

      // stable pattern, then extra identical strobes
      expq.push_back(4'h5);
      settle(7'b0100100);
      tick();
      chk("pass_valid", hex_valid, 1);
      chk("pass_hex", hex_out, 4'h5);
      for (int i = 0; i < 2; i++) begin
         if (!FILT)
            expq.push_back(4'h5);
         strobe(7'b0100100);
      end
      repeat (3) tick();
      chk("pass_quiet", hex_valid, 0);
      chk("pass_drained", expq.size(), 0);

      // changing pattern restarts the filter
      for (int i = 0; i < 4; i++) begin
         if (!FILT)
            expq.push_back(rj_hex[i]);
         strobe(rj_seg[i]);
      end
      repeat (3) tick();
      chk("rej_quiet", hex_valid, 0);
      chk("rej_drained", expq.size(), 0);

      // overrun while valid is held
      hex_ready = 1'b0;
      expq.push_back(4'h1);
      settle(7'b1001111);
      tick();
      chk("ovr_valid1", hex_valid, 1);
      chk("ovr_hex1", hex_out, 4'h1);
      chk("ovr_flag0", overrun, 0);
      settle(7'b0001000);
      tick();
      chk("ovr_hex", hex_out, 4'h1);
      chk("ovr_valid", hex_valid, 1);
      chk("ovr_flag", overrun, 1);
      hex_ready = 1'b1;
      tick();
      hex_ready = 1'b0;
      chk("ovr_xfer_valid", hex_valid, 0);
      pulse_clr();
      chk("ovr_clr", overrun, 0);

      // overrun set and clear on the same edge
      expq.push_back(4'hC);
      settle(7'b0110001);
      tick();
      chk("sw_valid", hex_valid, 1);
      settle(7'b1000010);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("sw_ovr", overrun, 1);
      pulse_clr();
      chk("sw_clr", overrun, 0);
      chk("sw_hex_held", hex_out, 4'hC);
      hex_ready = 1'b1;
      tick();
      hex_ready = 1'b0;
      chk("sw_drain", hex_valid, 0);

      // back-to-back episodes, ready held high
      hex_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         expq.push_back(tbl[i + 6].hex);
         settle(tbl[i + 6].seg);
      end
      repeat (3) tick();
      chk("burst_drained", expq.size(), 0);
      chk("burst_valid", hex_valid, 0);

      // reset mid-operation
      hex_ready = 1'b0;
      strobe(7'b0110000);
      strobe(7'b0110000);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rstmid_out", {hex_out, hex_valid, err, overrun}, 0);
      tick();
      chk("rstmid_quiet", {hex_valid, err, overrun}, 0);
      hex_ready = 1'b1;
      for (int i = 1; i <= SC; i++) begin
         if (!FILT || i == SC)
            expq.push_back(4'hE);
         strobe(7'b0110000);
      end
      repeat (3) tick();
      chk("rstmid_drained", expq.size(), 0);
      chk("rstmid_valid", hex_valid, 0);

      repeat (2) tick();
      chk("final_queue", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
